// File: rtl/serial_cmd_master_pkg.sv
// serial_cmd_master_pkg: command byte constants and FSM state encodings for the serial command master
package serial_cmd_master_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  typedef enum logic [1:0] {S_IDLE, S_GET_ADR, S_GET_DAT, S_BUS} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, centre sampling and stop-bit check
module uart_rx_byte
  import serial_cmd_master_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_t rs, rs_next;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [2:0] sync;
  logic rx, fall, tick;
  assign rx = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign tick = cnt == (rs == RX_START ? HALF : LAST);
  always_comb begin
    rs_next = rs;
    unique case (rs)
      RX_IDLE:  if (fall) rs_next = RX_START;
      RX_START: if (tick) rs_next = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) rs_next = RX_STOP;
      RX_STOP:  if (tick) rs_next = RX_IDLE;
      default:  rs_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync <= '1;
      rs <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[1:0], rxd};
      rs <= rs_next;
      cnt <= (rs == RX_IDLE || tick) ? '0 : cnt + 1'b1;
      byte_valid <= rs == RX_STOP && tick && rx;
      frame_err <= rs == RX_STOP && tick && !rx;
      if (rs == RX_DATA && tick) begin
        byte_data <= {rx, byte_data[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_cmd_master.sv
// serial_cmd_master: UART 'W'/'R' command frames to single Wishbone master cycles.
// Optional ack timeout enabled by defining SERIAL_CMD_ACK_TIMEOUT_EN.
module serial_cmd_master
  import serial_cmd_master_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd,
  output logic       stb_o,
  output logic       we_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       err_o
);
  state_t state, next;
  logic byte_valid, frame_err, hold_full, consume, perr, ovr, tmo;
  logic [7:0] byte_data, hold_data;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rxd(rxd),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );
  assign consume = hold_full && state != S_BUS;
  assign ovr = byte_valid && hold_full && !consume;
  assign perr = consume && state == S_IDLE && hold_data != CMD_WRITE && hold_data != CMD_READ;
  assign stb_o = state == S_BUS;
  assign busy_o = state != S_IDLE;
`ifdef SERIAL_CMD_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) tcnt <= '0;
    else tcnt <= stb_o ? tcnt + 1'b1 : '0;
  end
  // an ack in the limit cycle wins over the timeout
  assign tmo = stb_o && !ack_i && tcnt == TMAX;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    if (consume && !perr) next = S_GET_ADR;
      S_GET_ADR: if (consume) next = we_o ? S_GET_DAT : S_BUS;
      S_GET_DAT: if (consume) next = S_BUS;
      S_BUS:     if (ack_i || tmo) next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      we_o <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= next;
      err_o <= frame_err | perr | ovr | tmo;
      if (byte_valid && !ovr) begin
        hold_full <= 1'b1;
        hold_data <= byte_data;
      end else if (consume) hold_full <= 1'b0;
      if (consume && state == S_IDLE && !perr) we_o <= hold_data == CMD_WRITE;
      if (consume && state == S_GET_ADR) adr_o <= hold_data;
      if (consume && state == S_GET_DAT) dat_o <= hold_data;
    end
  end
endmodule

// File: doc/serial_cmd_master.md
# serial_cmd_master

Inbound serial command decoder for the host link: receives 8N1 UART bytes on the LPC TXD1 line, parses 'W'/'R' command frames and issues single Wishbone master cycles on the core's 8-bit register bus. It is the receive-side counterpart of the serialized read-return path. Read data is not returned here: the existing read FIFO snoops the bus cycle and transmits it.

## Interface
- CLKS_PER_BIT, default 16: system clocks per UART bit; must be ≥ 4.
- ACK_TIMEOUT, default 255: maximum cycles `stb_o` is held waiting for `ack_i`; only used with the timeout feature.
- clk_i  in  1  system clock (GLA). One clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- rxd  in  1  asynchronous serial input (TX1); idle high.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  8  Wishbone address; [7:4] selects the channel, [3:0] the register.
- dat_o  out  8  Wishbone write data.
- ack_i  in  1  Wishbone acknowledge from the interconnect mux.
- busy_o  out  1  high while a frame is partially received or a bus cycle is pending.
- err_o  out  1  one-cycle pulse on framing error, bad command byte, overrun or ack timeout.

## Operation
- Receiver: `rxd` passes through a 2-flop synchronizer.
  - A falling edge in idle starts a bit counter.
  - At CLKS_PER_BIT/2 the line must still be low, otherwise the start bit is false and the receiver returns to idle silently.
  - The 8 data bits are sampled LSB-first at bit centres.
  - The stop bit is sampled at its centre. If it is 1, the byte is valid; if it is 0, it is a framing error: the byte is discarded and `err_o` pulses.
  - The receiver re-arms immediately after the stop-bit sample.
- Byte holding register: one entry. A valid byte sets `hold_full`, and the parser consumes it.
  - If a new byte completes while `hold_full` is set, that is an overrun: the new byte is dropped and `err_o` pulses.
- Parser FSM: IDLE, GET_ADR, GET_DAT, BUS.
  - IDLE: byte 0x57 ('W') latches we=1 and goes to GET_ADR. Byte 0x52 ('R') latches we=0 and goes to GET_ADR. Any other byte pulses `err_o` and stays in IDLE.
  - GET_ADR: latches `adr_o`. If we=1, go to GET_DAT; otherwise go to BUS.
  - GET_DAT: latches `dat_o` and goes to BUS.
  - BUS: `stb_o`=1. On the first cycle with `ack_i`=1, `stb_o` drops on the next edge and the FSM returns to IDLE.
  - Bytes received during BUS remain in the holding register and are consumed after IDLE is re-entered.
- `adr_o`, `dat_o` and `we_o` are stable for the whole time `stb_o` is high. For reads, `dat_o` keeps its previous value.
- `busy_o` = (state != IDLE).
- Reset (any cycle, including mid-byte or mid-cycle):
  - Registers: FSM to IDLE, receiver to idle, `hold_full`=0.
  - Outputs: `stb_o`=0, `we_o`=0, `adr_o`=0x00, `dat_o`=0x00, `err_o`=0, `busy_o`=0.

## Timing
- Synchronizer latency is 2 cycles.
- A byte is valid at the start-edge detect plus 9.5×CLKS_PER_BIT cycles (±1).
- The parser consumes a held byte the cycle after it becomes valid.
- `stb_o` rises 1 cycle after the final byte of a frame is consumed.
- `ack_i` sampled high at edge N: `stb_o`=0 after edge N+1 is not allowed; `stb_o` must be low from edge N onward, i.e. registered deassert on edge N.
- The minimum bus cycle is 1 cycle with `stb_o` high when `ack_i` is combinationally returned.
- `err_o` is asserted for exactly one cycle per event.
- If a framing error and a parser error occur in the same cycle, a single pulse is issued.

## Configuration
- SERIAL_CMD_ACK_TIMEOUT_EN defined: in BUS, a counter starts at 0 when `stb_o` rises.
  - If it reaches ACK_TIMEOUT without `ack_i`, `stb_o` drops, `err_o` pulses and the FSM returns to IDLE.
  - If `ack_i` arrives in the same cycle the limit is reached, it counts as an ack: no error.
- Undefined: no counter; BUS waits for `ack_i` indefinitely.

## Structure
- The shared package (alongside reg_defs) holds the command byte constants `CMD_WRITE`=0x57 and `CMD_READ`=0x52, plus the FSM state encodings.
- Sub-module `uart_rx_byte`: synchronizer, bit timing and stop check.
  - Outputs: `byte_valid` pulse, `byte_data[7:0]`, `frame_err` pulse.
  - Parameter: CLKS_PER_BIT.
- Parser, holding register and Wishbone logic stay in the top module.

## Test plan
- Write: with CLKS_PER_BIT=4, send 0x57, 0x31, 0xA5; slave acks after 3 cycles. Required: one cycle with `stb_o`=1, `we_o`=1, `adr_o`=0x31, `dat_o`=0xA5, held 3 cycles; `err_o` never pulses.
- Read: send 0x52, 0x92. Required: `stb_o` with `we_o`=0, `adr_o`=0x92; return to IDLE after ack; `busy_o` low afterwards.
- Bad command: send 0x00 and then a byte whose stop bit is 0. Required: two separate `err_o` pulses, no `stb_o`, FSM remains IDLE.
- Back-to-back: send two write frames with no idle gap while the first ack is delayed by 40 cycles. Required: both cycles issued in order with no overrun; a third byte arriving while the hold register is full gives an `err_o` pulse.
- Timeout: with the macro defined and ACK_TIMEOUT=10, hold `ack_i` low. Required: `stb_o` falls after 10 cycles, with an `err_o` pulse. Without the macro, `stb_o` stays high for 100 or more cycles.
- Reset mid-frame: assert `rst_i` after 'W' and the address byte. Required: all outputs at reset values, and a following complete read frame executes normally.
